// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : spi_pkg
//  Purpose  : FSM state encodings and SCK edge-role helpers for the SPI
//             slave.
//  Revision : 1.0 - initial release
// ============================================================================
package spi_pkg;

    // Transfer FSM encodings
    localparam logic [0:0] c_st_idle   = 1'b0;
    localparam logic [0:0] c_st_active = 1'b1;

    // Leading edge is the transition away from the idle level
    function automatic logic lead_edge(input logic cpol, input logic rise, input logic fall);
        return cpol ? fall : rise;
    endfunction

    // Trailing edge is the transition back to the idle level
    function automatic logic trail_edge(input logic cpol, input logic rise, input logic fall);
        return cpol ? rise : fall;
    endfunction

    // MOSI is sampled on the leading edge for CPHA=0, on the trailing edge otherwise
    function automatic logic sample_edge(input logic cpol, input logic cpha,
                                         input logic rise, input logic fall);
        return cpha ? trail_edge(cpol, rise, fall) : lead_edge(cpol, rise, fall);
    endfunction

    // MISO moves on whichever edge does not sample
    function automatic logic shift_edge(input logic cpol, input logic cpha,
                                        input logic rise, input logic fall);
        return cpha ? lead_edge(cpol, rise, fall) : trail_edge(cpol, rise, fall);
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sync.sv
`default_nettype none
// ============================================================================
//  Module   : spi_sync
//  Purpose  : N-stage single-bit synchroniser with a selectable reset level.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_sync #(
    parameter int STAGES  = 2,
    parameter bit RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Shift the asynchronous input one stage per clock
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    // Synchroniser chain, reset to the pin's idle level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/spi_slave_word.sv
`default_nettype none
// ============================================================================
//  Module   : spi_slave_word
//  Purpose  : SPI slave with configurable word width, mode and bit order,
//             valid/ready handshakes on rx and tx, overrun/underrun flags.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_slave_word
    import spi_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter bit CPOL        = 1'b0,
    parameter bit CPHA        = 1'b0,
    parameter bit LSB_FIRST   = 1'b0,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sck,
    input  logic              mosi,
    input  logic              ssel,
    output logic              miso,
    output logic              miso_oe,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              overrun,
    output logic              underrun,
    output logic              busy
);

    localparam int                c_cnt_w = $clog2(DATA_W);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(DATA_W - 1);

    logic w_sck_s, w_mosi_s, w_ssel_s;
    logic w_sck_rise, w_sck_fall, w_ssel_fall, w_ssel_rise;
    logic w_sample, w_shift, w_do_load;
    logic [DATA_W-1:0] w_rx_next, w_tx_next;

    logic [0:0]         state_q, state_d;
    logic [c_cnt_w-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0]  rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0]  rx_data_q, rx_data_d;
    logic               rx_valid_q, rx_valid_d;
    logic [DATA_W-1:0]  tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0]  hold_q, hold_d;
    logic               hold_full_q, hold_full_d;
    logic               word_done_q, word_done_d;
    logic               skip_q, skip_d;
    logic               overrun_q, overrun_d;
    logic               underrun_q, underrun_d;
    logic               sck_prev_q, sck_prev_d;
    logic               ssel_prev_q, ssel_prev_d;

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sync_sck (
        .clk(clk), .rst_n(rst_n), .d(sck), .q(w_sck_s));
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .d(mosi), .q(w_mosi_s));
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ssel (
        .clk(clk), .rst_n(rst_n), .d(ssel), .q(w_ssel_s));

    assign w_sck_rise  =  w_sck_s & ~sck_prev_q;
    assign w_sck_fall  = ~w_sck_s &  sck_prev_q;
    assign w_ssel_fall = ~w_ssel_s &  ssel_prev_q;
    assign w_ssel_rise =  w_ssel_s & ~ssel_prev_q;
    assign w_sample    = sample_edge(CPOL, CPHA, w_sck_rise, w_sck_fall);
    assign w_shift     = shift_edge(CPOL, CPHA, w_sck_rise, w_sck_fall);

    // The word that is being shifted out moves toward the bit presented on MISO
    assign w_rx_next = LSB_FIRST ? {w_mosi_s, rx_shift_q[DATA_W-1:1]}
                                 : {rx_shift_q[DATA_W-2:0], w_mosi_s};
    assign w_tx_next = LSB_FIRST ? {1'b0, tx_shift_q[DATA_W-1:1]}
                                 : {tx_shift_q[DATA_W-2:0], 1'b0};

    // Next-state logic: FSM, bit counter, rx/tx shifting and handshakes
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rx_shift_d  = rx_shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        tx_shift_d  = tx_shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        word_done_d = word_done_q;
        skip_d      = skip_q;
        overrun_d   = 1'b0;
        underrun_d  = 1'b0;
        sck_prev_d  = w_sck_s;
        ssel_prev_d = w_ssel_s;
        w_do_load   = 1'b0;

        // Acceptance; a word completed in this same cycle re-asserts below
        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end

        case (state_q)
            c_st_idle: begin
                cnt_d       = '0;
                word_done_d = 1'b0;
                skip_d      = 1'b0;
                if (w_ssel_fall) begin
                    state_d   = c_st_active;
                    w_do_load = 1'b1;
                    // With CPHA=1 the load already presents bit 0, so the
                    // first leading edge must leave the register alone
                    skip_d    = CPHA;
                end
            end
            default: begin
                if (w_ssel_rise) begin
                    // Abort: partial rx bits and the in-flight tx word are dropped
                    state_d     = c_st_idle;
                    cnt_d       = '0;
                    tx_shift_d  = '0;
                    word_done_d = 1'b0;
                    skip_d      = 1'b0;
                end else begin
                    if (w_sample) begin
                        rx_shift_d = w_rx_next;
                        if (cnt_q == c_last) begin
                            cnt_d       = '0;
                            word_done_d = 1'b1;
                            if (!rx_valid_q || rx_ready) begin
                                rx_data_d  = w_rx_next;
                                rx_valid_d = 1'b1;
                            end else begin
                                overrun_d = 1'b1;
                            end
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    if (w_shift) begin
                        if (word_done_q) begin
                            w_do_load   = 1'b1;
                            word_done_d = 1'b0;
                        end else if (skip_q) begin
                            skip_d = 1'b0;
                        end else begin
                            tx_shift_d = w_tx_next;
                        end
                    end
                end
            end
        endcase

        // Word load from the holding register, or zeros when nothing is queued
        if (w_do_load) begin
            if (hold_full_q) begin
                tx_shift_d  = hold_q;
                hold_full_d = 1'b0;
            end else begin
                tx_shift_d = '0;
                underrun_d = 1'b1;
            end
        end

        // Holding register only accepts while empty, so it never races a load
        if (tx_valid && !hold_full_q) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= c_st_idle;
            cnt_q       <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            tx_shift_q  <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            word_done_q <= 1'b0;
            skip_q      <= 1'b0;
            overrun_q   <= 1'b0;
            underrun_q  <= 1'b0;
            sck_prev_q  <= CPOL;
            ssel_prev_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            tx_shift_q  <= tx_shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            word_done_q <= word_done_d;
            skip_q      <= skip_d;
            overrun_q   <= overrun_d;
            underrun_q  <= underrun_d;
            sck_prev_q  <= sck_prev_d;
            ssel_prev_q <= ssel_prev_d;
        end
    end

    assign miso     = LSB_FIRST ? tx_shift_q[0] : tx_shift_q[DATA_W-1];
    assign busy     = (state_q == c_st_active);
    assign miso_oe  = busy;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign tx_ready = ~hold_full_q;
    assign overrun  = overrun_q;
    assign underrun = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_word.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_slave_word
//  Purpose  : Directed self-checking bench: mode 0 / 8-bit MSB-first and
//             mode 3 / 16-bit LSB-first instances of spi_slave_word.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_slave_word;

    localparam int HP = 80;   // SCK half period, 8 clk periods

    logic clk = 1'b0;
    logic rst_n;

    logic        sck0, mosi0, ssel0, miso0, miso_oe0, rx_valid0, rx_ready0;
    logic [7:0]  rx_data0, tx_data0;
    logic        tx_valid0, tx_ready0, overrun0, underrun0, busy0;

    logic        sck1, mosi1, ssel1, miso1, miso_oe1, rx_valid1, rx_ready1;
    logic [15:0] rx_data1, tx_data1;
    logic        tx_valid1, tx_ready1, overrun1, underrun1, busy1;

    int n_cmp = 0;
    int n_bad = 0;
    int ov0 = 0, ur0 = 0, rxr0 = 0, ov1 = 0, ur1 = 0;
    logic rxv0_prev = 1'b0;
    int base_ov, base_ur, base_rxr;
    logic [15:0] mi16;

    always #5 clk = ~clk;

    spi_slave_word #(.DATA_W(8), .CPOL(1'b0), .CPHA(1'b0), .LSB_FIRST(1'b0),
                     .SYNC_STAGES(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .sck(sck0), .mosi(mosi0), .ssel(ssel0),
        .miso(miso0), .miso_oe(miso_oe0), .rx_data(rx_data0), .rx_valid(rx_valid0),
        .rx_ready(rx_ready0), .tx_data(tx_data0), .tx_valid(tx_valid0),
        .tx_ready(tx_ready0), .overrun(overrun0), .underrun(underrun0), .busy(busy0));

    spi_slave_word #(.DATA_W(16), .CPOL(1'b1), .CPHA(1'b1), .LSB_FIRST(1'b1),
                     .SYNC_STAGES(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .sck(sck1), .mosi(mosi1), .ssel(ssel1),
        .miso(miso1), .miso_oe(miso_oe1), .rx_data(rx_data1), .rx_valid(rx_valid1),
        .rx_ready(rx_ready1), .tx_data(tx_data1), .tx_valid(tx_valid1),
        .tx_ready(tx_ready1), .overrun(overrun1), .underrun(underrun1), .busy(busy1));

    // Pulse and rising-edge counters, sampled away from the active edge
    always @(negedge clk) begin
        if (overrun0)  ov0++;
        if (underrun0) ur0++;
        if (overrun1)  ov1++;
        if (underrun1) ur1++;
        if (rx_valid0 && !rxv0_prev) rxr0++;
        rxv0_prev = rx_valid0;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push0(input logic [7:0] d);
        int n = 0;
        while (!tx_ready0 && n < 100) begin #10; n++; end
        check("push0_ready", 32'(tx_ready0), 32'd1);
        tx_data0 = d; tx_valid0 = 1'b1;
        #10;
        tx_valid0 = 1'b0;
    endtask

    task automatic push1(input logic [15:0] d);
        int n = 0;
        while (!tx_ready1 && n < 100) begin #10; n++; end
        check("push1_ready", 32'(tx_ready1), 32'd1);
        tx_data1 = d; tx_valid1 = 1'b1;
        #10;
        tx_valid1 = 1'b0;
    endtask

    // Mode 0 master, MSB first; bit i of the frame is mo[15-i]
    task automatic frame0(input logic [15:0] mo, input int nbits, output logic [15:0] mi);
        mi = '0;
        ssel0 = 1'b0;
        #(HP);
        for (int i = 0; i < nbits; i++) begin
            mosi0 = mo[15-i];
            #(HP);
            sck0 = 1'b1;
            mi[15-i] = miso0;
            #(HP);
            sck0 = 1'b0;
        end
        #(HP);
        ssel0 = 1'b1;
        #(2*HP);
    endtask

    // Mode 3 master, 16 bits LSB first
    task automatic frame1(input logic [15:0] mo, output logic [15:0] mi);
        mi = '0;
        ssel1 = 1'b0;
        #(HP);
        for (int i = 0; i < 16; i++) begin
            sck1 = 1'b0;
            mosi1 = mo[i];
            #(HP);
            sck1 = 1'b1;
            mi[i] = miso1;
            #(HP);
        end
        ssel1 = 1'b1;
        #(2*HP);
    endtask

    task automatic accept0();
        rx_ready0 = 1'b1;
        #10;
        rx_ready0 = 1'b0;
        check("accept0_clears", 32'(rx_valid0), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        sck0 = 1'b0; mosi0 = 1'b0; ssel0 = 1'b1; rx_ready0 = 1'b0; tx_data0 = '0; tx_valid0 = 1'b0;
        sck1 = 1'b1; mosi1 = 1'b0; ssel1 = 1'b1; rx_ready1 = 1'b0; tx_data1 = '0; tx_valid1 = 1'b0;
        #42;
        // Reset state
        check("rst_miso",     32'(miso0),     32'd0);
        check("rst_miso_oe",  32'(miso_oe0),  32'd0);
        check("rst_rx_data",  32'(rx_data0),  32'd0);
        check("rst_rx_valid", 32'(rx_valid0), 32'd0);
        check("rst_tx_ready", 32'(tx_ready0), 32'd1);
        check("rst_busy",     32'(busy0),     32'd0);
        check("rst1_tx_ready", 32'(tx_ready1), 32'd1);
        check("rst1_busy",     32'(busy1),     32'd0);
        rst_n = 1'b1;
        #40;

        // Mode 0: 0xA5 out, 0x3C in; next word queued before the last shift edge
        base_ov = ov0; base_ur = ur0; base_rxr = rxr0;
        push0(8'hA5);
        check("m0_tx_ready_full", 32'(tx_ready0), 32'd0);
        fork
            frame0({8'h3C, 8'h00}, 8, mi16);
            begin #(4*HP); push0(8'h5A); end
        join
        check("m0_rx_data",  32'(rx_data0),     32'h3C);
        check("m0_rx_valid", 32'(rx_valid0),    32'd1);
        check("m0_miso",     32'(mi16[15:8]),   32'hA5);
        check("m0_rxv_once", 32'(rxr0 - base_rxr), 32'd1);
        check("m0_overrun",  32'(ov0 - base_ov),   32'd0);
        check("m0_underrun", 32'(ur0 - base_ur),   32'd0);
        check("m0_busy_end", 32'(busy0),        32'd0);
        check("m0_oe_end",   32'(miso_oe0),     32'd0);
        accept0();
        check("m0_tx_ready_after", 32'(tx_ready0), 32'd1);

        // Overrun: two words, rx_ready held low
        base_ov = ov0; base_rxr = rxr0;
        frame0({8'hC3, 8'h96}, 16, mi16);
        check("ovr_rx_data",  32'(rx_data0),  32'hC3);
        check("ovr_rx_valid", 32'(rx_valid0), 32'd1);
        check("ovr_pulses",   32'(ov0 - base_ov),   32'd1);
        check("ovr_rxv_once", 32'(rxr0 - base_rxr), 32'd1);
        check("ovr_miso_zero", 32'(mi16), 32'h0000);
        accept0();

        // Abort after 5 bits, then a full word
        base_rxr = rxr0;
        frame0({8'hB0, 8'h00}, 5, mi16);
        check("abort_rx_valid", 32'(rx_valid0), 32'd0);
        check("abort_busy",     32'(busy0),     32'd0);
        check("abort_no_rxv",   32'(rxr0 - base_rxr), 32'd0);
        frame0({8'h69, 8'h00}, 8, mi16);
        check("post_abort_rx",  32'(rx_data0),  32'h69);
        check("post_abort_vld", 32'(rx_valid0), 32'd1);

        // Asynchronous reset mid-transfer (rx word 0x69 left pending)
        push0(8'hE7);
        ssel0 = 1'b0;
        #(HP);
        for (int i = 0; i < 2; i++) begin
            mosi0 = 1'b1;
            #(HP);
            sck0 = 1'b1;
            #(HP);
            sck0 = 1'b0;
        end
        push0(8'h18);
        #(HP);
        check("pre_rst_busy",     32'(busy0),     32'd1);
        check("pre_rst_miso",     32'(miso0),     32'd1);
        check("pre_rst_tx_ready", 32'(tx_ready0), 32'd0);
        rst_n = 1'b0;
        #1;
        check("arst_miso",     32'(miso0),     32'd0);
        check("arst_miso_oe",  32'(miso_oe0),  32'd0);
        check("arst_rx_data",  32'(rx_data0),  32'd0);
        check("arst_rx_valid", 32'(rx_valid0), 32'd0);
        check("arst_tx_ready", 32'(tx_ready0), 32'd1);
        check("arst_overrun",  32'(overrun0),  32'd0);
        check("arst_underrun", 32'(underrun0), 32'd0);
        check("arst_busy",     32'(busy0),     32'd0);
        #9;
        ssel0 = 1'b1; mosi0 = 1'b0;
        #40;
        rst_n = 1'b1;
        #(2*HP);
        push0(8'h81);
        frame0({8'h7E, 8'h00}, 8, mi16);
        check("post_rst_rx",   32'(rx_data0),   32'h7E);
        check("post_rst_vld",  32'(rx_valid0),  32'd1);
        check("post_rst_miso", 32'(mi16[15:8]), 32'h81);
        accept0();

        // Mode 3, 16-bit, LSB first
        base_ov = ov1; base_ur = ur1;
        push1(16'h1234);
        frame1(16'hBEEF, mi16);
        check("m3_rx_data",  32'(rx_data1),  32'hBEEF);
        check("m3_rx_valid", 32'(rx_valid1), 32'd1);
        check("m3_miso",     32'(mi16),      32'h1234);
        check("m3_overrun",  32'(ov1 - base_ov), 32'd0);
        check("m3_underrun", 32'(ur1 - base_ur), 32'd0);
        rx_ready1 = 1'b1;
        #10;
        rx_ready1 = 1'b0;
        check("m3_accept", 32'(rx_valid1), 32'd0);

        // Underrun: nothing queued before ssel falls
        base_ur = ur1;
        check("ur_tx_ready_pre", 32'(tx_ready1), 32'd1);
        frame1(16'h0F0F, mi16);
        check("ur_miso_zero", 32'(mi16),      32'h0000);
        check("ur_pulses",    32'(ur1 - base_ur), 32'd1);
        check("ur_tx_ready",  32'(tx_ready1), 32'd1);
        check("ur_rx_data",   32'(rx_data1),  32'h0F0F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_slave_word.md
# spi_slave_word

Parametrised SPI slave with selectable word width, SPI mode (CPOL/CPHA), bit order and valid/ready handshakes on both the receive and transmit sides. It sits between an external SPI master's pins and on-chip logic in the `clk` domain. All pin inputs are synchronised internally. It reports receive overrun and transmit underrun instead of silently corrupting data.

## Interface
Parameters:
- `DATA_W`, 8: bits per SPI word, legal range 2..32.
- `CPOL`, 0: SCK idle level.
- `CPHA`, 0: 0 means sample on the leading edge; 1 means sample on the trailing edge.
- `LSB_FIRST`, 0: 0 means MSB shifted first on both MOSI and MISO.
- `SYNC_STAGES`, 2: synchroniser depth for sck, mosi and ssel, legal range 2..4.

Ports:
- `clk`, in, 1: system clock. One clock only.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `sck`, in, 1: SPI clock, asynchronous to `clk`.
- `mosi`, in, 1: master data out.
- `ssel`, in, 1: slave select, active-low.
- `miso`, out, 1: slave data out.
- `miso_oe`, out, 1: output enable for the MISO pad; high while selected.
- `rx_data`, out, DATA_W: received word.
- `rx_valid`, out, 1: `rx_data` is valid; held until accepted.
- `rx_ready`, in, 1: consumer accepts the word when `rx_valid && rx_ready`.
- `tx_data`, in, DATA_W: word to transmit.
- `tx_valid`, in, 1: `tx_data` is offered.
- `tx_ready`, out, 1: the transmit holding register is empty.
- `overrun`, out, 1: one-cycle pulse when a received word is dropped.
- `underrun`, out, 1: one-cycle pulse when a word starts with no tx data available.
- `busy`, out, 1: a transfer is in progress (state ACTIVE).

## Operation
- **Synchronisation:** sck, mosi and ssel each pass through SYNC_STAGES flops. One further sck register gives edge detection.
- **Edge roles:**
  - Leading edge = transition away from CPOL.
  - Sample edge = leading edge if CPHA=0, else trailing edge.
  - Shift edge = the other edge.
- **FSM IDLE:** miso_oe=0 and the bit counter is cleared. On synced ssel going low, go to ACTIVE and perform a word load.
- **FSM ACTIVE:** on synced ssel going high, return to IDLE from any bit position.
- **Word load (tx):**
  - If the holding register is full, copy it to the tx shift register and free the holding register (tx_ready rises the next cycle).
  - If it is empty, load all zeros and pulse underrun.
  - Word loads occur on entry to ACTIVE and on the shift edge that follows a completed word.
  - When CPHA=1, the first leading (shift) edge of each word does not shift; the MSB is already presented by the load.
- **Receive:**
  - Each sample edge shifts mosi into the rx shift register and increments a counter of width $clog2(DATA_W).
  - The counter wraps to 0 after DATA_W−1.
  - On the DATA_W-th sample, if rx_valid=0 or rx_ready=1 in that cycle, write the word to `rx_data` and set rx_valid. Otherwise pulse overrun, discard the new word and keep the old one.
- **Transmit:** miso = shift register MSB, or LSB when LSB_FIRST. The register shifts on every shift edge except the load edge.
- **Handshakes:**
  - rx_valid clears on `rx_valid && rx_ready` unless a new word is written in the same cycle, in which case it stays high with the new data.
  - The holding register loads on `tx_valid && tx_ready`.
- **Abort:** ssel rising mid-word discards partial rx bits and the tx shift register. No rx_valid is raised. A word already moved out of the holding register is lost. The holding register contents are kept.

## Timing
- **Reset values:** miso=0, miso_oe=0, rx_data=0, rx_valid=0, tx_ready=1, overrun=0, underrun=0, busy=0. The FSM is in IDLE.
- **Edge detection:** a pin edge is detected in cycle E, at most SYNC_STAGES+1 clk edges after the pin transition.
- **Receive latency:** rx_data/rx_valid update in cycle E+1 of the final sample edge.
- **Transmit latency:** miso updates in cycle E+1 of a shift edge or an ssel assertion.
- **Host requirements:**
  - Each SCK half-period must be at least SYNC_STAGES+3 clk periods.
  - ssel-low to first SCK edge must be at least SYNC_STAGES+3 clk periods.
  - ssel-high time must be at least SYNC_STAGES+2 clk periods.
- **Bursts:** back-to-back words without ssel deassertion are supported. tx_data must be handed over before the last shift edge of the current word.

## Structure
- **Package `spi_pkg`:** state enum (IDLE, ACTIVE) and edge-select helper functions taking CPOL/CPHA.
- **Sub-module `spi_sync`:** a parametrised N-stage single-bit synchroniser with async active-low reset, instantiated three times.

## Test plan
- **Mode 0, 8 bits:** tx_data=0xA5 preloaded, master sends 0x3C → rx_data=0x3C with one rx_valid; master receives 0xA5; no flags.
- **Mode 3, LSB_FIRST=1, DATA_W=16:** tx=0x1234, master sends 0xBEEF → rx=0xBEEF; master sees 0x1234 LSB first.
- **Overrun:** two 8-bit words in one ssel frame with rx_ready=0 → first word held, overrun pulses once, rx_data keeps the first word.
- **Underrun:** no tx_valid before ssel falls → MISO shifts 0x00 and underrun pulses once; tx_ready stays 1.
- **Abort:** ssel deasserted after 5 bits → no rx_valid, busy=0; the next full word is received correctly.
- **Reset:** rst_n asserted mid-transfer → all outputs return to reset values asynchronously; a transfer after release works.
